// File: rtl/pkt_pkg.sv
// Shared types and helpers for the packet write-side controller:
// FSM state encoding, header field layout and eop byte-enable mapping.
package pkt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOP,
        DATA,
        DRAIN,
        HDR_WR,
        TS_WR,
        DONE
    } state_t;

    localparam int TRUNC_BIT = 31;
    localparam int WCNT_MSB  = 30;
    localparam int WCNT_LSB  = 16;
    localparam int BLEN_MSB  = 15;
    localparam int BLEN_LSB  = 0;

    // s_empty counts unused high bytes, so enables cover the low bytes only
    function automatic logic [3:0] empty_to_be(input logic [1:0] empty);
        logic [3:0] be;
        case (empty)
            2'd0:    be = 4'hF;
            2'd1:    be = 4'h7;
            2'd2:    be = 4'h3;
            default: be = 4'h1;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] build_hdr(input logic        trunc,
                                              input logic [14:0] wcnt,
                                              input logic [15:0] blen);
        logic [31:0] h;
        h                     = '0;
        h[TRUNC_BIT]          = trunc;
        h[WCNT_MSB:WCNT_LSB]  = wcnt;
        h[BLEN_MSB:BLEN_LSB]  = blen;
        return h;
    endfunction

endpackage

// File: rtl/pkt_wr_ctrl.sv
// Captures one streamed frame into a word-addressed memory ring behind a reserved
// header slot, then writes the header. Optional feature macro: PKT_WR_TIMESTAMP_EN.
module pkt_wr_ctrl
    import pkt_pkg::*;
#(
    parameter int          ADDR_W        = 32,
    parameter int unsigned RING_BASE     = 0,
    parameter int          RING_WORDS    = 4096,
    parameter int          MAX_PKT_WORDS = 380,
    localparam int         PTR_W         = $clog2(RING_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_ctrl,
    output logic              wr_ctrl_rdy,
    input  logic [31:0]       s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_sop,
    input  logic              s_eop,
    input  logic [1:0]        s_empty,
    output logic [ADDR_W-1:0] m_address,
    output logic [31:0]       m_writedata,
    output logic [3:0]        m_byteenable,
    output logic              m_write,
    input  logic              m_waitrequest,
    output logic [PTR_W-1:0]  wr_ptr_out,
    output logic [15:0]       pkt_count
);

`ifdef PKT_WR_TIMESTAMP_EN
    localparam int HDR_SLOTS = 2;
`else
    localparam int HDR_SLOTS = 1;
`endif

    localparam logic [14:0] MAX_W = 15'(MAX_PKT_WORDS);

    state_t              r_state;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_hdr_ptr;
    logic [14:0]         r_wcnt;
    logic [15:0]         r_blen;
    logic                r_trunc;
    logic                r_eop_seen;
    logic                r_rdy;
    logic [15:0]         r_pkt_count;
    logic [ADDR_W-1:0]   r_m_address;
    logic [31:0]         r_m_writedata;
    logic [3:0]          r_m_be;
    logic                r_m_write;
`ifdef PKT_WR_TIMESTAMP_EN
    logic [31:0]         r_cycle;
    logic [31:0]         r_ts;
`endif

    logic                w_wr_done;
    logic                w_acc;
    logic                w_beat;
    logic                w_store;
    logic [2:0]          w_beat_bytes;
    logic [15:0]         w_blen_nxt;

    function automatic logic [15:0] blen_sat_add(input logic [15:0] a, input logic [2:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {14'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    function automatic logic [ADDR_W-1:0] ring_addr(input logic [PTR_W-1:0] ptr);
        return ADDR_W'(RING_BASE) + ADDR_W'({ptr, 2'b00});
    endfunction

    assign w_wr_done    = !r_m_write || !m_waitrequest;
    assign w_acc        = s_valid && s_ready;
    assign w_beat       = w_acc && ((r_state == DATA) || ((r_state == WAIT_SOP) && s_sop));
    assign w_store      = (r_wcnt < MAX_W);
    assign w_beat_bytes = s_eop ? (3'd4 - {1'b0, s_empty}) : 3'd4;
    assign w_blen_nxt   = blen_sat_add(r_blen, w_beat_bytes);

    // Once the eop beat is taken, stop accepting until the frame's last write retires
    always_comb begin
        s_ready = 1'b0;
        case (r_state)
            WAIT_SOP: s_ready = 1'b1;
            DATA:     s_ready = !r_eop_seen && w_wr_done;
            DRAIN:    s_ready = 1'b1;
            default:  s_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_wr_ptr      <= '0;
            r_hdr_ptr     <= '0;
            r_wcnt        <= '0;
            r_blen        <= '0;
            r_trunc       <= 1'b0;
            r_eop_seen    <= 1'b0;
            r_rdy         <= 1'b0;
            r_pkt_count   <= '0;
            r_m_address   <= '0;
            r_m_writedata <= '0;
            r_m_be        <= '0;
            r_m_write     <= 1'b0;
`ifdef PKT_WR_TIMESTAMP_EN
            r_ts          <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_m_write <= 1'b0;
                    if (wr_ctrl) begin
                        r_hdr_ptr  <= r_wr_ptr;
                        r_wr_ptr   <= r_wr_ptr + PTR_W'(HDR_SLOTS);
                        r_wcnt     <= '0;
                        r_blen     <= '0;
                        r_trunc    <= 1'b0;
                        r_eop_seen <= 1'b0;
                        r_state    <= WAIT_SOP;
                    end
                end

                WAIT_SOP, DATA: begin
                    if (w_beat) begin
                        r_blen <= w_blen_nxt;
`ifdef PKT_WR_TIMESTAMP_EN
                        if (r_state == WAIT_SOP) r_ts <= r_cycle;
`endif
                        if (w_store) begin
                            r_m_write     <= 1'b1;
                            r_m_address   <= ring_addr(r_wr_ptr);
                            r_m_writedata <= s_data;
                            r_m_be        <= s_eop ? empty_to_be(s_empty) : 4'hF;
                            r_wr_ptr      <= r_wr_ptr + PTR_W'(1);
                            r_wcnt        <= r_wcnt + 15'd1;
                            r_eop_seen    <= s_eop;
                            r_state       <= DATA;
                        end else begin
                            r_trunc <= 1'b1;
                            if (s_eop) begin
                                r_m_write     <= 1'b1;
                                r_m_address   <= ring_addr(r_hdr_ptr);
                                r_m_writedata <= build_hdr(1'b1, r_wcnt, w_blen_nxt);
                                r_m_be        <= 4'hF;
                                r_state       <= HDR_WR;
                            end else begin
                                r_m_write <= 1'b0;
                                r_state   <= DRAIN;
                            end
                        end
                    end else if (w_wr_done) begin
                        if (r_eop_seen) begin
                            r_m_write     <= 1'b1;
                            r_m_address   <= ring_addr(r_hdr_ptr);
                            r_m_writedata <= build_hdr(r_trunc, r_wcnt, r_blen);
                            r_m_be        <= 4'hF;
                            r_state       <= HDR_WR;
                        end else begin
                            r_m_write <= 1'b0;
                        end
                    end
                end

                DRAIN: begin
                    if (w_acc) begin
                        r_blen <= w_blen_nxt;
                        if (s_eop) begin
                            r_m_write     <= 1'b1;
                            r_m_address   <= ring_addr(r_hdr_ptr);
                            r_m_writedata <= build_hdr(1'b1, r_wcnt, w_blen_nxt);
                            r_m_be        <= 4'hF;
                            r_state       <= HDR_WR;
                        end
                    end
                end

                HDR_WR: begin
                    if (!m_waitrequest) begin
`ifdef PKT_WR_TIMESTAMP_EN
                        r_m_address   <= ring_addr(r_hdr_ptr + PTR_W'(1));
                        r_m_writedata <= r_ts;
                        r_m_be        <= 4'hF;
                        r_state       <= TS_WR;
`else
                        r_m_write   <= 1'b0;
                        r_pkt_count <= r_pkt_count + 16'd1;
                        r_rdy       <= 1'b1;
                        r_state     <= DONE;
`endif
                    end
                end

`ifdef PKT_WR_TIMESTAMP_EN
                TS_WR: begin
                    if (!m_waitrequest) begin
                        r_m_write   <= 1'b0;
                        r_pkt_count <= r_pkt_count + 16'd1;
                        r_rdy       <= 1'b1;
                        r_state     <= DONE;
                    end
                end
`endif

                DONE: begin
                    r_m_write <= 1'b0;
                    if (!wr_ctrl) begin
                        r_rdy   <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_m_write <= 1'b0;
                    r_rdy     <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

`ifdef PKT_WR_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (reset) r_cycle <= '0;
        else       r_cycle <= r_cycle + 32'd1;
    end
`endif

    assign wr_ctrl_rdy  = r_rdy;
    assign m_address    = r_m_address;
    assign m_writedata  = r_m_writedata;
    assign m_byteenable = r_m_be;
    assign m_write      = r_m_write;
    assign wr_ptr_out   = r_wr_ptr;
    assign pkt_count    = r_pkt_count;

endmodule
